dispatch_ctrl: RTL and testbench

- Issue-stage controller that sequences the register file on behalf of the decoder.
- Accepts one decoded instruction per handshake and holds it in a one-entry skid register.
- Reads rs1/rs2 through the register file read ports, allocates a ROB tag, and marks rd busy through the set_dep port.
- Dispatches a fully-formed entry to either the reservation station (RS) or the load/store buffer (LSB).
- Sits between decoder and RS/LSB/ROB; sole driver of the regfile get/set_dep ports.

---
 rtl/dispatch_pkg.sv | 26 ++
 rtl/dispatch_ctrl_pipe_reg.sv | 85 ++++++++
 rtl/dispatch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_dispatch_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_pkg.sv
// dispatch_pkg
// Shared constants and types for the issue-stage dispatch controller.
// Carries the ROB tag width used across regfile/ROB, the decoded opcode
// width, dispatch entry field widths and the controller state encoding.
package dispatch_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned REG_IDX_W = 5;
   localparam int unsigned ROB_R     = 3;
   localparam int unsigned OP_W_DEF  = 6;

   typedef logic [XLEN-1:0]      word_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [ROB_R-1:0]     rob_tag_t;

   typedef enum logic {
      ST_EMPTY,
      ST_HOLD
   } disp_state_t;

   // Unused operands read x0 so the regfile reports a clean, zero value.
   function automatic reg_idx_t masked_idx(input logic use_r, input reg_idx_t idx);
      return use_r ? idx : '0;
   endfunction

endpackage

// File: rtl/dispatch_ctrl_pipe_reg.sv
// dispatch_pipe_reg
// Registered dispatch entry plus a one-cycle valid pulse toward either the
// reservation station or the load/store buffer.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (freeze), rob_clear (flush)
//   fire, fire_is_mem     : dispatch request and its target
//   in_*                  : fully-formed entry captured on fire
//   rs_valid, lsb_valid   : pulse for the cycle after fire
//   out_*                 : registered entry, held between dispatches
module dispatch_pipe_reg
   import dispatch_pkg::*;
#(
   parameter int unsigned ROB_W = ROB_R,
   parameter int unsigned OP_W  = OP_W_DEF
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             rdy_in,
   input  logic             rob_clear,
   input  logic             fire,
   input  logic             fire_is_mem,
   input  logic [OP_W-1:0]  in_op,
   input  logic [XLEN-1:0]  in_vj,
   input  logic [XLEN-1:0]  in_vk,
   input  logic [ROB_W-1:0] in_qj,
   input  logic [ROB_W-1:0] in_qk,
   input  logic             in_has_qj,
   input  logic             in_has_qk,
   input  logic [XLEN-1:0]  in_imm,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [ROB_W-1:0] in_dest,
   output logic             rs_valid,
   output logic             lsb_valid,
   output logic [OP_W-1:0]  out_op,
   output logic [XLEN-1:0]  out_vj,
   output logic [XLEN-1:0]  out_vk,
   output logic [ROB_W-1:0] out_qj,
   output logic [ROB_W-1:0] out_qk,
   output logic             out_has_qj,
   output logic             out_has_qk,
   output logic [XLEN-1:0]  out_imm,
   output logic [XLEN-1:0]  out_pc,
   output logic [ROB_W-1:0] out_dest
);

   logic take;
   assign take = fire && !rob_clear;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rs_valid   <= 1'b0;
         lsb_valid  <= 1'b0;
         out_op     <= '0;
         out_vj     <= '0;
         out_vk     <= '0;
         out_qj     <= '0;
         out_qk     <= '0;
         out_has_qj <= 1'b0;
         out_has_qk <= 1'b0;
         out_imm    <= '0;
         out_pc     <= '0;
         out_dest   <= '0;
      end else if (!rdy_in) begin
         // Frozen: entry fields hold, but no pulse may linger.
         rs_valid  <= 1'b0;
         lsb_valid <= 1'b0;
      end else begin
         rs_valid  <= take && !fire_is_mem;
         lsb_valid <= take && fire_is_mem;
         if (take) begin
            out_op     <= in_op;
            out_vj     <= in_vj;
            out_vk     <= in_vk;
            out_qj     <= in_qj;
            out_qk     <= in_qk;
            out_has_qj <= in_has_qj;
            out_has_qk <= in_has_qk;
            out_imm    <= in_imm;
            out_pc     <= in_pc;
            out_dest   <= in_dest;
         end
      end
   end

endmodule

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl
// Issue-stage controller between the decoder and RS/LSB/ROB. Holds one
// decoded instruction, reads its operands through the regfile read ports,
// allocates a ROB tag, marks rd busy and dispatches a complete entry.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (freeze), rob_clear (flush)
//   dec_*        : decoder handshake and decoded fields
//   rf_get_id_*  : operand read indices; rf_val/has_dep/dep_* : results
//   rf_set_dep_* : rd busy marking (id 0 = none)
//   rob_full/rob_tail/rob_push : ROB allocation
//   rs_full/lsb_full, rs_valid/lsb_valid, out_* : dispatch interface
//   issue_cnt    : instructions dispatched since reset
module dispatch_ctrl
   import dispatch_pkg::*;
#(
   parameter int unsigned ROB_W = ROB_R,
   parameter int unsigned OP_W  = OP_W_DEF
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 rob_clear,
   input  logic                 dec_valid,
   output logic                 dec_ready,
   input  logic [OP_W-1:0]      dec_op,
   input  logic [REG_IDX_W-1:0] dec_rd,
   input  logic [REG_IDX_W-1:0] dec_rs1,
   input  logic [REG_IDX_W-1:0] dec_rs2,
   input  logic                 dec_use_rs1,
   input  logic                 dec_use_rs2,
   input  logic                 dec_is_mem,
   input  logic [XLEN-1:0]      dec_imm,
   input  logic [XLEN-1:0]      dec_pc,
   output logic [REG_IDX_W-1:0] rf_get_id_1,
   output logic [REG_IDX_W-1:0] rf_get_id_2,
   input  logic [XLEN-1:0]      rf_val_1,
   input  logic [XLEN-1:0]      rf_val_2,
   input  logic                 rf_has_dep_1,
   input  logic                 rf_has_dep_2,
   input  logic [ROB_W-1:0]     rf_dep_1,
   input  logic [ROB_W-1:0]     rf_dep_2,
   output logic [REG_IDX_W-1:0] rf_set_dep_id,
   output logic [ROB_W-1:0]     rf_set_dep_q,
   input  logic                 rob_full,
   input  logic [ROB_W-1:0]     rob_tail,
   output logic                 rob_push,
   input  logic                 rs_full,
   input  logic                 lsb_full,
   output logic                 rs_valid,
   output logic                 lsb_valid,
   output logic [OP_W-1:0]      out_op,
   output logic [XLEN-1:0]      out_vj,
   output logic [XLEN-1:0]      out_vk,
   output logic [ROB_W-1:0]     out_qj,
   output logic [ROB_W-1:0]     out_qk,
   output logic                 out_has_qj,
   output logic                 out_has_qk,
   output logic [XLEN-1:0]      out_imm,
   output logic [XLEN-1:0]      out_pc,
   output logic [ROB_W-1:0]     out_dest,
   output logic [XLEN-1:0]      issue_cnt
);

   typedef struct packed {
      logic [OP_W-1:0] op;
      reg_idx_t        rd;
      reg_idx_t        rs1;
      reg_idx_t        rs2;
      logic            use_rs1;
      logic            use_rs2;
      logic            is_mem;
      word_t           imm;
      word_t           pc;
   } entry_t;

   disp_state_t state;
   entry_t      held;
   logic        fire;
   logic        sel_full;
   logic        accept;

   always_comb begin
      sel_full = held.is_mem ? lsb_full : rs_full;
      fire     = (state == ST_HOLD) && !rob_full && !sel_full && !rob_clear && rdy_in;
      // Accepting while firing keeps the single holding register streaming.
      dec_ready     = ((state == ST_EMPTY) || fire) && !rob_clear && rdy_in;
      rob_push      = fire;
      rf_set_dep_id = fire ? held.rd : '0;
      rf_set_dep_q  = fire ? rob_tail : '0;
      rf_get_id_1   = '0;
      rf_get_id_2   = '0;
      if (state == ST_HOLD) begin
         rf_get_id_1 = masked_idx(held.use_rs1, held.rs1);
         rf_get_id_2 = masked_idx(held.use_rs2, held.rs2);
      end
   end

   assign accept = dec_valid && dec_ready;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state     <= ST_EMPTY;
         held      <= '0;
         issue_cnt <= '0;
      end else if (rdy_in) begin
         if (rob_clear) begin
            state <= ST_EMPTY;
         end else if (accept) begin
            state        <= ST_HOLD;
            held.op      <= dec_op;
            held.rd      <= dec_rd;
            held.rs1     <= dec_rs1;
            held.rs2     <= dec_rs2;
            held.use_rs1 <= dec_use_rs1;
            held.use_rs2 <= dec_use_rs2;
            held.is_mem  <= dec_is_mem;
            held.imm     <= dec_imm;
            held.pc      <= dec_pc;
         end else if (fire) begin
            state <= ST_EMPTY;
         end
         if (fire) begin
            issue_cnt <= issue_cnt + 32'd1;
         end
      end
   end

   dispatch_pipe_reg #(
      .ROB_W (ROB_W),
      .OP_W  (OP_W)
   ) u_pipe (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .rdy_in      (rdy_in),
      .rob_clear   (rob_clear),
      .fire        (fire),
      .fire_is_mem (held.is_mem),
      .in_op       (held.op),
      .in_vj       (rf_val_1),
      .in_vk       (rf_val_2),
      .in_qj       (rf_dep_1),
      .in_qk       (rf_dep_2),
      .in_has_qj   (rf_has_dep_1),
      .in_has_qk   (rf_has_dep_2),
      .in_imm      (held.imm),
      .in_pc       (held.pc),
      .in_dest     (rob_tail),
      .rs_valid    (rs_valid),
      .lsb_valid   (lsb_valid),
      .out_op      (out_op),
      .out_vj      (out_vj),
      .out_vk      (out_vk),
      .out_qj      (out_qj),
      .out_qk      (out_qk),
      .out_has_qj  (out_has_qj),
      .out_has_qk  (out_has_qk),
      .out_imm     (out_imm),
      .out_pc      (out_pc),
      .out_dest    (out_dest)
   );

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl
// Directed and randomized checking of dispatch_ctrl against a transaction
// model: one optional held instruction, a scoreboarded expected dispatch and
// a behavioural regfile/ROB environment.
module tb_dispatch_ctrl;

   localparam int ROB_W = 3;
   localparam int OP_W  = 6;

   logic              clk_in, rst_in, rdy_in, rob_clear;
   logic              dec_valid, dec_ready;
   logic [OP_W-1:0]   dec_op;
   logic [4:0]        dec_rd, dec_rs1, dec_rs2;
   logic              dec_use_rs1, dec_use_rs2, dec_is_mem;
   logic [31:0]       dec_imm, dec_pc;
   logic [4:0]        rf_get_id_1, rf_get_id_2;
   logic [31:0]       rf_val_1, rf_val_2;
   logic              rf_has_dep_1, rf_has_dep_2;
   logic [ROB_W-1:0]  rf_dep_1, rf_dep_2;
   logic [4:0]        rf_set_dep_id;
   logic [ROB_W-1:0]  rf_set_dep_q;
   logic              rob_full, rob_push;
   logic [ROB_W-1:0]  rob_tail;
   logic              rs_full, lsb_full, rs_valid, lsb_valid;
   logic [OP_W-1:0]   out_op;
   logic [31:0]       out_vj, out_vk, out_imm, out_pc, issue_cnt;
   logic [ROB_W-1:0]  out_qj, out_qk, out_dest;
   logic              out_has_qj, out_has_qk;

   // Environment regfile: value, busy flag and producer tag per register.
   logic [31:0]      regs [32];
   logic             busy [32];
   logic [ROB_W-1:0] tagm [32];

   assign rf_val_1     = regs[rf_get_id_1];
   assign rf_val_2     = regs[rf_get_id_2];
   assign rf_has_dep_1 = busy[rf_get_id_1];
   assign rf_has_dep_2 = busy[rf_get_id_2];
   assign rf_dep_1     = busy[rf_get_id_1] ? tagm[rf_get_id_1] : '0;
   assign rf_dep_2     = busy[rf_get_id_2] ? tagm[rf_get_id_2] : '0;

   dispatch_ctrl #(.ROB_W(ROB_W), .OP_W(OP_W)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
      .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
      .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_is_mem(dec_is_mem),
      .dec_imm(dec_imm), .dec_pc(dec_pc),
      .rf_get_id_1(rf_get_id_1), .rf_get_id_2(rf_get_id_2),
      .rf_val_1(rf_val_1), .rf_val_2(rf_val_2),
      .rf_has_dep_1(rf_has_dep_1), .rf_has_dep_2(rf_has_dep_2),
      .rf_dep_1(rf_dep_1), .rf_dep_2(rf_dep_2),
      .rf_set_dep_id(rf_set_dep_id), .rf_set_dep_q(rf_set_dep_q),
      .rob_full(rob_full), .rob_tail(rob_tail), .rob_push(rob_push),
      .rs_full(rs_full), .lsb_full(lsb_full),
      .rs_valid(rs_valid), .lsb_valid(lsb_valid),
      .out_op(out_op), .out_vj(out_vj), .out_vk(out_vk),
      .out_qj(out_qj), .out_qk(out_qk),
      .out_has_qj(out_has_qj), .out_has_qk(out_has_qk),
      .out_imm(out_imm), .out_pc(out_pc), .out_dest(out_dest),
      .issue_cnt(issue_cnt)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [OP_W-1:0] op;
      logic [4:0]      rd, rs1, rs2;
      logic            u1, u2, mem;
      logic [31:0]     imm, pc;
   } instr_t;

   typedef struct {
      logic [OP_W-1:0]  op;
      logic [31:0]      vj, vk, imm, pc;
      logic [ROB_W-1:0] qj, qk, dest;
      logic             hj, hk, mem;
   } disp_t;

   int     n_assert = 0;
   int     n_fail   = 0;
   bit     m_held   = 0;
   instr_t m_ent;
   int unsigned m_cnt = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic read_op(input logic u, input logic [4:0] r, output logic [31:0] v,
                          output logic h, output logic [ROB_W-1:0] q);
      logic [4:0] id;
      id = u ? r : 5'd0;
      v  = (id == 0) ? 32'd0 : regs[id];
      h  = (id == 0) ? 1'b0 : busy[id];
      q  = h ? tagm[id] : '0;
   endtask

   // One clock: combinational checks mid-cycle, edge, then model/env update
   // and checks of the registered dispatch interface.
   task automatic tick();
      bit sel_full, m_fire, m_ready, m_accept, push;
      logic [4:0] sid;
      logic [ROB_W-1:0] sq;
      disp_t d;
      instr_t nxt;
      #4;
      sel_full = m_ent.mem ? lsb_full : rs_full;
      m_fire   = rdy_in && m_held && !rob_full && !sel_full && !rob_clear;
      m_ready  = rdy_in && !rob_clear && (!m_held || m_fire);
      m_accept = dec_valid && m_ready;
      chk("dec_ready", dec_ready, m_ready);
      chk("rob_push", rob_push, m_fire);
      chk("set_dep_id", rf_set_dep_id, m_fire ? m_ent.rd : 5'd0);
      chk("set_dep_q", rf_set_dep_q, m_fire ? rob_tail : '0);
      chk("get_id_1", rf_get_id_1, (m_held && m_ent.u1) ? m_ent.rs1 : 5'd0);
      chk("get_id_2", rf_get_id_2, (m_held && m_ent.u2) ? m_ent.rs2 : 5'd0);
      d = '{default: '0};
      if (m_fire) begin
         read_op(m_ent.u1, m_ent.rs1, d.vj, d.hj, d.qj);
         read_op(m_ent.u2, m_ent.rs2, d.vk, d.hk, d.qk);
         d.op = m_ent.op; d.imm = m_ent.imm; d.pc = m_ent.pc;
         d.dest = rob_tail; d.mem = m_ent.mem;
      end
      nxt = '{op: dec_op, rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2, u1: dec_use_rs1,
              u2: dec_use_rs2, mem: dec_is_mem, imm: dec_imm, pc: dec_pc};
      push = rob_push; sid = rf_set_dep_id; sq = rf_set_dep_q;
      @(posedge clk_in);
      #1;
      if (push) rob_tail = rob_tail + 1'b1;
      if (sid != 0) begin
         busy[sid] = 1'b1;
         tagm[sid] = sq;
      end
      if (rdy_in) begin
         if (rob_clear) m_held = 0;
         else if (m_accept) begin
            m_held = 1;
            m_ent  = nxt;
         end else if (m_fire) m_held = 0;
      end
      if (m_fire) m_cnt++;
      chk("rs_valid", rs_valid, m_fire && !d.mem);
      chk("lsb_valid", lsb_valid, m_fire && d.mem);
      chk("issue_cnt", issue_cnt, m_cnt);
      if (m_fire) begin
         chk("out_op", out_op, d.op);
         chk("out_vj", out_vj, d.vj);
         chk("out_vk", out_vk, d.vk);
         chk("out_qj", out_qj, d.qj);
         chk("out_qk", out_qk, d.qk);
         chk("out_has_qj", out_has_qj, d.hj);
         chk("out_has_qk", out_has_qk, d.hk);
         chk("out_imm", out_imm, d.imm);
         chk("out_pc", out_pc, d.pc);
         chk("out_dest", out_dest, d.dest);
      end
   endtask

   task automatic offer(input logic [OP_W-1:0] op, input logic [4:0] rd, rs1, rs2,
                        input logic u1, u2, mem);
      dec_valid = 1; dec_op = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
      dec_use_rs1 = u1; dec_use_rs2 = u2; dec_is_mem = mem;
      dec_imm = $urandom; dec_pc = $urandom;
   endtask

   task automatic env_clear();
      for (int i = 0; i < 32; i++) begin
         busy[i] = 1'b0;
         tagm[i] = '0;
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
      env_clear();
      m_ent = '{default: '0};
      rst_in = 0; rdy_in = 1; rob_clear = 0; rob_full = 0; rs_full = 0; lsb_full = 0;
      rob_tail = '0; dec_valid = 0;
      offer(6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      dec_valid = 0;
      #12 rst_in = 1;
      @(posedge clk_in); #1;

      // ADD rd=5 rs1=1 rs2=2, then SUB rs1=5 back-to-back.
      regs[1] = 32'd10; regs[2] = 32'd20; rob_tail = 3'd3;
      offer(6'd1, 5'd5, 5'd1, 5'd2, 1, 1, 0); tick();
      offer(6'd2, 5'd6, 5'd5, 5'd2, 1, 1, 0); tick();
      chk("t2_rs_valid", rs_valid, 1'b1);
      chk("t2_vj", out_vj, 32'd10);
      chk("t2_vk", out_vk, 32'd20);
      chk("t2_dest", out_dest, 3'd3);
      dec_valid = 0; tick();
      chk("t3_has_qj", out_has_qj, 1'b1);
      chk("t3_qj", out_qj, 3'd3);
      chk("t3_dest", out_dest, 3'd4);
      chk("t3_cnt", issue_cnt, 32'd2);

      // Asynchronous reset while holding a stalled entry.
      rs_full = 1;
      offer(6'd3, 5'd9, 5'd1, 5'd2, 1, 1, 0); tick();
      dec_valid = 0; tick();
      rst_in = 0;
      #1;
      chk("rst_push", rob_push, 1'b0);
      chk("rst_get1", rf_get_id_1, 5'd0);
      chk("rst_setdep", rf_set_dep_id, 5'd0);
      chk("rst_rs_valid", rs_valid, 1'b0);
      chk("rst_vj", out_vj, 32'd0);
      chk("rst_dest", out_dest, 3'd0);
      chk("rst_cnt", issue_cnt, 32'd0);
      @(posedge clk_in); #1;
      rst_in = 1; rs_full = 0;
      m_held = 0; m_cnt = 0; env_clear();
      tick();

      // Load stalled three cycles by lsb_full.
      lsb_full = 1;
      offer(6'd4, 5'd7, 5'd3, 5'd0, 1, 0, 1); tick();
      dec_valid = 0;
      for (int i = 0; i < 3; i++) tick();
      lsb_full = 0; tick();
      chk("t4_lsb_valid", lsb_valid, 1'b1);
      tick();

      // rd=0 with rs2 unused.
      regs[7] = 32'd77;
      offer(6'd5, 5'd0, 5'd3, 5'd7, 1, 0, 0); tick();
      dec_valid = 0; tick();
      chk("t5_vk", out_vk, 32'd0);
      chk("t5_has_qk", out_has_qk, 1'b0);

      // Flush in the fire cycle, then a freeze while holding.
      offer(6'd6, 5'd8, 5'd1, 5'd2, 1, 1, 0); tick();
      dec_valid = 0; rob_clear = 1; tick();
      rob_clear = 0; tick();
      offer(6'd7, 5'd10, 5'd1, 5'd2, 1, 1, 0); tick();
      dec_valid = 0; rdy_in = 0; tick(); tick();
      rdy_in = 1; tick();
      chk("t6_rs_valid", rs_valid, 1'b1);
      chk("t6_op", out_op, 6'd7);

      // Randomized traffic with an environment that retires producers.
      for (int c = 0; c < 600; c++) begin
         dec_valid   = ($urandom_range(0, 9) < 7);
         dec_op      = 6'($urandom);
         dec_rd      = 5'($urandom);
         dec_rs1     = 5'($urandom);
         dec_rs2     = 5'($urandom);
         dec_use_rs1 = 1'($urandom);
         dec_use_rs2 = 1'($urandom);
         dec_is_mem  = 1'($urandom);
         dec_imm     = $urandom;
         dec_pc      = $urandom;
         rob_full    = ($urandom_range(0, 9) == 0);
         rs_full     = ($urandom_range(0, 4) == 0);
         lsb_full    = ($urandom_range(0, 4) == 0);
         rob_clear   = ($urandom_range(0, 19) == 0);
         rdy_in      = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 2) == 0) begin
            int unsigned r;
            r = $urandom_range(1, 31);
            busy[r] = 1'b0;
            regs[r] = $urandom;
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
